// File: rtl/eeprom_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// eeprom_access_arbiter_if
//   Bundles the two requester channels, the response signals and the EEPROM
//   byte-port command/result signals of eeprom_access_arbiter.
//
// Handshake semantics (one place, applies to every channel below):
//   * reqN is a level: the requester holds it (with weN/addrN/wdataN stable)
//     until ackN pulses for one cycle. The command fields are sampled only in
//     the cycle the arbiter grants.
//   * errN and rdata are meaningful in the ackN cycle; rdata then holds until
//     the next ack.
//   * eep_enable is a one-cycle command strobe. eep_valid=1 means the EEPROM
//     port is idle / has a result; it falls to accept a command and rises
//     again with eep_rdata valid.
//
// Modports
//   slave  : arbiter side (requests and EEPROM results in, responses and
//            EEPROM commands out)
//   master : environment side (requesters plus EEPROM byte port)
// ---------------------------------------------------------------------------
interface eeprom_access_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [15:0] addr0;
  logic [15:0] addr1;
  logic [7:0]  wdata0;
  logic [7:0]  wdata1;
  logic        ack0;
  logic        ack1;
  logic        err0;
  logic        err1;
  logic [7:0]  rdata;
  logic        eep_enable;
  logic        eep_wr;
  logic [15:0] eep_addr;
  logic [7:0]  eep_wdata;
  logic        eep_valid;
  logic [7:0]  eep_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  eep_valid, eep_rdata,
    output ack0, ack1, err0, err1, rdata,
    output eep_enable, eep_wr, eep_addr, eep_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output eep_valid, eep_rdata,
    input  ack0, ack1, err0, err1, rdata,
    input  eep_enable, eep_wr, eep_addr, eep_wdata
  );
endinterface

// File: rtl/eeprom_access_arbiter.sv
// ---------------------------------------------------------------------------
// eeprom_access_arbiter
//   Shares one EEPROM byte port between two requesters. A round-robin grant
//   picks a requester when the port is idle, its command is latched and
//   strobed once, the arbiter waits for the port to go busy and then ready
//   again, captures the result byte and pulses the winner's ack.
//
// Parameters
//   TIMEOUT_CYC : max cycles to wait in WAIT_DONE for eep_valid to rise
//   ISSUE_CYC   : max cycles to wait in WAIT_BUSY for eep_valid to fall
//
// Ports
//   clk       : system clock, posedge
//   rst_n     : asynchronous active-low reset
//   bus       : eeprom_access_arbiter_if.slave (requesters + EEPROM port)
//   state_dbg : current FSM state encoding (IDLE=0 ISSUE=1 WAIT_BUSY=2
//               WAIT_DONE=3 RESP=4)
//
// Build option
//   EEP_ARB_TIMEOUT_EN : when defined, WAIT_BUSY/WAIT_DONE give up after
//   ISSUE_CYC/TIMEOUT_CYC cycles and answer with err=1. When undefined they
//   wait forever, err0/err1 are constant 0 and no counter exists.
// ---------------------------------------------------------------------------
module eeprom_access_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 2_500_000,
  parameter int unsigned ISSUE_CYC   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  eeprom_access_arbiter_if.slave        bus,
  output logic [2:0]                    state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        gnt;        // requester owning the current transaction
  logic        last_gnt;   // requester granted most recently
  logic        pick;       // requester that would win this cycle
  logic        grant_now;
  logic        busy_to;    // WAIT_BUSY limit reached this cycle
  logic        done_to;    // WAIT_DONE limit reached this cycle
  logic        err_q;

  logic        eep_wr_q;
  logic [15:0] eep_addr_q;
  logic [7:0]  eep_wdata_q;
  logic [7:0]  rdata_q;

  // Round-robin: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    pick = 1'b0;
    if (bus.req0 && bus.req1) pick = ~last_gnt;
    else if (bus.req1)        pick = 1'b1;
  end

  assign grant_now = (state == S_IDLE) && bus.eep_valid && (bus.req0 || bus.req1);

`ifdef EEP_ARB_TIMEOUT_EN
  localparam logic [31:0] ISSUE_LIM   = (ISSUE_CYC == 0)   ? 32'd0 : 32'(ISSUE_CYC - 1);
  localparam logic [31:0] TIMEOUT_LIM = (TIMEOUT_CYC == 0) ? 32'd0 : 32'(TIMEOUT_CYC - 1);

  logic [31:0] cnt;

  // cnt holds the number of full cycles already spent in the current state,
  // so the limit compare fires in the last allowed cycle.
  assign busy_to = (cnt >= ISSUE_LIM);
  assign done_to = (cnt >= TIMEOUT_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 32'd0;
    end else if (state_nxt != state) begin
      cnt <= 32'd0;
    end else if (cnt != 32'hFFFF_FFFF) begin
      cnt <= cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (grant_now) begin
      err_q <= 1'b0;
    end else if ((state == S_WAIT_BUSY &&  bus.eep_valid && busy_to) ||
                 (state == S_WAIT_DONE && !bus.eep_valid && done_to)) begin
      err_q <= 1'b1;
    end
  end
`else
  assign busy_to = 1'b0;
  assign done_to = 1'b0;
  assign err_q   = 1'b0;

  // Limits only matter with timeouts enabled; an empty block keeps the
  // parameters referenced in this build.
  if (TIMEOUT_CYC == 0 || ISSUE_CYC == 0) begin : g_no_limits
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (grant_now) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (!bus.eep_valid) state_nxt = S_WAIT_DONE;
        else if (busy_to)   state_nxt = S_RESP;
      end
      S_WAIT_DONE: begin
        if (bus.eep_valid)  state_nxt = S_RESP;
        else if (done_to)   state_nxt = S_RESP;
      end
      S_RESP:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Command latch, result capture and round-robin pointer.
  // Command fields stay put from grant until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= 1'b0;
      last_gnt    <= 1'b1;
      eep_wr_q    <= 1'b0;
      eep_addr_q  <= 16'd0;
      eep_wdata_q <= 8'd0;
      rdata_q     <= 8'd0;
    end else begin
      if (grant_now) begin
        gnt         <= pick;
        eep_wr_q    <= pick ? bus.we1    : bus.we0;
        eep_addr_q  <= pick ? bus.addr1  : bus.addr0;
        eep_wdata_q <= pick ? bus.wdata1 : bus.wdata0;
      end
      if (state == S_WAIT_DONE && bus.eep_valid) rdata_q <= bus.eep_rdata;
      if (state == S_RESP) last_gnt <= gnt;
    end
  end

  // Output logic
  always_comb begin
    bus.eep_enable = (state == S_ISSUE);
    bus.ack0       = (state == S_RESP) && !gnt;
    bus.ack1       = (state == S_RESP) &&  gnt;
    bus.err0       = (state == S_RESP) && !gnt && err_q;
    bus.err1       = (state == S_RESP) &&  gnt && err_q;
  end

  assign bus.eep_wr    = eep_wr_q;
  assign bus.eep_addr  = eep_addr_q;
  assign bus.eep_wdata = eep_wdata_q;
  assign bus.rdata     = rdata_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_eeprom_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_eeprom_access_arbiter
//   Directed bench for eeprom_access_arbiter. Requester drivers push the
//   expected command and response into queues; monitors pop and compare when
//   the DUT strobes eep_enable or pulses an ack. A small EEPROM byte-port
//   model answers commands (normal, valid stuck high, valid stuck low).
// ---------------------------------------------------------------------------
module tb_eeprom_access_arbiter;
  localparam int unsigned TO_CYC = 100;
  localparam int unsigned IS_CYC = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  eeprom_access_arbiter_if bus();
  logic [2:0] state_dbg;

  eeprom_access_arbiter #(
    .TIMEOUT_CYC (TO_CYC),
    .ISSUE_CYC   (IS_CYC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [9:0]  exp_q[$];   // {requester, err, rdata}
  logic [24:0] cmd_q[$];   // {wr, addr, wdata}
  int total = 0;
  int bad   = 0;
  int n_ack0 = 0;
  int n_ack1 = 0;
  int n_en   = 0;
  int en_cyc = 0;
  int ack_cyc = 0;

  // EEPROM model controls: 0 normal, 1 valid never falls, 2 valid never rises
  int mode = 0;
  int busy_cyc = 3;
  logic [7:0] mem [0:65535];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_enable"}, 32'(bus.eep_enable), 32'd0);
    check({tag, "_wr"},     32'(bus.eep_wr),     32'd0);
    check({tag, "_addr"},   32'(bus.eep_addr),   32'd0);
    check({tag, "_wdata"},  32'(bus.eep_wdata),  32'd0);
    check({tag, "_rdata"},  32'(bus.rdata),      32'd0);
    check({tag, "_ackerr"}, 32'({bus.ack0, bus.ack1, bus.err0, bus.err1}), 32'd0);
    check({tag, "_state"},  32'(state_dbg),      32'd0);
  endtask

  // ---------------- monitors ----------------
  initial begin
    logic [9:0]  e;
    logic [24:0] c;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.ack0 || bus.ack1)) begin
        ack_cyc = cyc;
        if (bus.ack0) n_ack0++;
        if (bus.ack1) n_ack1++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b expected none", bus.ack0, bus.ack1);
        end else begin
          e = exp_q.pop_front();
          check("ack_resp",
                32'({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.rdata}),
                32'({~e[9], e[9], (e[9] ? 1'b0 : e[8]), (e[9] ? e[8] : 1'b0), e[7:0]}));
        end
      end
      if (rst_n && bus.eep_enable) begin
        if (cmd_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_enable: got addr=%0h expected none", bus.eep_addr);
        end else begin
          c = cmd_q.pop_front();
          check("eep_cmd", 32'({bus.eep_wr, bus.eep_addr, bus.eep_wdata}), 32'(c));
        end
      end
    end
  end

  // ---------------- EEPROM byte-port model ----------------
  initial begin
    logic        wr;
    logic [15:0] a;
    logic [7:0]  wd;
    forever begin
      @(negedge clk);
      if (rst_n && bus.eep_enable) begin
        en_cyc = cyc;
        n_en++;
        wr = bus.eep_wr;
        a  = bus.eep_addr;
        wd = bus.eep_wdata;
        if (mode == 0) begin
          bus.eep_valid = 1'b0;
          repeat (busy_cyc) @(negedge clk);
          if (wr) mem[a] = wd;
          bus.eep_rdata = mem[a];
          bus.eep_valid = 1'b1;
        end else if (mode == 2) begin
          bus.eep_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_txn(input bit r, input bit we, input logic [15:0] a, input logic [7:0] wd,
                        input bit push, input bit exp_err, input logic [7:0] exp_rd,
                        input bit drop_early);
    int base_ack;
    int base_en;
    int t;
    if (push) begin
      exp_q.push_back({r, exp_err, exp_rd});
      cmd_q.push_back({we, a, wd});
    end
    base_en = n_en;
    if (!r) begin
      bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd; bus.req0 = 1'b1; base_ack = n_ack0;
    end else begin
      bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd; bus.req1 = 1'b1; base_ack = n_ack1;
    end
    t = 0;
    if (drop_early) begin
      while (n_en == base_en && t < 500) begin
        @(negedge clk); #1; t++;
      end
      if (!r) bus.req0 = 1'b0; else bus.req1 = 1'b0;
    end
    while (((!r) ? n_ack0 : n_ack1) == base_ack && t < 500) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 500) begin
      total++;
      bad++;
      $display("FAIL ack_wait: got no ack from requester %0d within 500 cycles expected ack", r);
    end
    if (!r) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    int base_en;
    int t;
    bus.req0 = 1'b0; bus.req1 = 1'b0; bus.we0 = 1'b0; bus.we1 = 1'b0;
    bus.addr0 = 16'd0; bus.addr1 = 16'd0; bus.wdata0 = 8'd0; bus.wdata1 = 8'd0;
    bus.eep_valid = 1'b1; bus.eep_rdata = 8'd0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'd0;
    mem[16'h0010] = 8'h5A;
    mem[16'h0100] = 8'h11; mem[16'h0101] = 8'h22; mem[16'h0102] = 8'h33;
    mem[16'h0200] = 8'h44; mem[16'h0201] = 8'h55; mem[16'h0202] = 8'h66;

    // reset values
    repeat (3) @(negedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single read by requester 0; model busy 3 cycles -> ack 4 cycles after strobe
    do_txn(1'b0, 1'b0, 16'h0010, 8'h00, 1'b1, 1'b0, 8'h5A, 1'b0);
    check("read_latency", 32'(ack_cyc - en_cyc), 32'd4);

    // write by requester 1, read-back echoes the data
    do_txn(1'b1, 1'b1, 16'h1234, 8'hC3, 1'b1, 1'b0, 8'hC3, 1'b0);

    // both requesters together; pointer last served 1, so 0 first, then alternate.
    // eep_valid low while they rise: no grant until it returns.
    exp_q.push_back({1'b0, 1'b0, 8'h11}); cmd_q.push_back({1'b0, 16'h0100, 8'h00});
    exp_q.push_back({1'b1, 1'b0, 8'h44}); cmd_q.push_back({1'b0, 16'h0200, 8'h00});
    exp_q.push_back({1'b0, 1'b0, 8'h22}); cmd_q.push_back({1'b0, 16'h0101, 8'h00});
    exp_q.push_back({1'b1, 1'b0, 8'h55}); cmd_q.push_back({1'b0, 16'h0201, 8'h00});
    exp_q.push_back({1'b0, 1'b0, 8'h33}); cmd_q.push_back({1'b0, 16'h0102, 8'h00});
    exp_q.push_back({1'b1, 1'b0, 8'h66}); cmd_q.push_back({1'b0, 16'h0202, 8'h00});
    bus.eep_valid = 1'b0;
    base_en = n_en;
    fork
      begin
        for (int k = 0; k < 3; k++)
          do_txn(1'b0, 1'b0, 16'h0100 + 16'(k), 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      end
      begin
        for (int k = 0; k < 3; k++)
          do_txn(1'b1, 1'b0, 16'h0200 + 16'(k), 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
      end
      begin
        repeat (5) @(negedge clk);
        #1;
        check("hold_no_grant_state", 32'(state_dbg), 32'd0);
        check("hold_no_grant_enable", 32'(n_en - base_en), 32'd0);
        bus.eep_valid = 1'b1;
      end
    join
    check("alt_count0", 32'(n_ack0), 32'd4);
    check("alt_count1", 32'(n_ack1), 32'd4);

`ifdef EEP_ARB_TIMEOUT_EN
    // valid never falls: err after ISSUE_CYC cycles in WAIT_BUSY, rdata kept
    mode = 1;
    do_txn(1'b0, 1'b0, 16'h0020, 8'h00, 1'b1, 1'b1, 8'h66, 1'b0);
    check("issue_to_latency", 32'(ack_cyc - en_cyc), 32'(IS_CYC + 1));
    // valid falls and never rises: 1 cycle WAIT_BUSY + TIMEOUT_CYC in WAIT_DONE
    mode = 2;
    do_txn(1'b1, 1'b0, 16'h0030, 8'h00, 1'b1, 1'b1, 8'h66, 1'b0);
    check("done_to_latency", 32'(ack_cyc - en_cyc), 32'(TO_CYC + 2));
    bus.eep_valid = 1'b1;
    mode = 0;
    repeat (2) @(negedge clk);
`endif

    // reset in WAIT_DONE aborts silently
    busy_cyc = 20;
    cmd_q.push_back({1'b0, 16'h0040, 8'h00});
    base_en = n_en;
    bus.we0 = 1'b0; bus.addr0 = 16'h0040; bus.wdata0 = 8'h00; bus.req0 = 1'b1;
    t = 0;
    while (n_en == base_en && t < 100) begin
      @(negedge clk); #1; t++;
    end
    check("abort_enable_seen", 32'(n_en - base_en), 32'd1);
    repeat (3) @(negedge clk);
    #1 check("abort_in_wait_done", 32'(state_dbg), 32'd3);
    rst_n = 1'b0;
    bus.req0 = 1'b0;
    #1 check_reset_vals("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = n_ack0 + n_ack1;
    base_en = n_en;
    repeat (30) @(negedge clk);
    #1;
    check("abort_no_ack", 32'(n_ack0 + n_ack1 - base), 32'd0);
    check("abort_no_enable", 32'(n_en - base_en), 32'd0);
    busy_cyc = 3;

    // next request served normally; request dropped right after grant
    do_txn(1'b0, 1'b1, 16'h0300, 8'h7E, 1'b1, 1'b0, 8'h7E, 1'b1);

    repeat (5) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eeprom_access_arbiter.md
EEPROM_ACCESS_ARBITER -- requirements
Module: eeprom_access_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 2_500_000, maximum clk cycles to wait for transaction completion (50 ms at 50 MHz).
REQ-002 Parameter ISSUE_CYC, default 8, maximum clk cycles to wait for eep_valid to fall after eep_enable.
REQ-003 clk  input  1  single system clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req0 / req1  input  1  requester 0/1 transaction request, level, held until ack.
REQ-006 we0 / we1  input  1  requester 0/1: 1 = write byte, 0 = read byte; sampled at grant.
REQ-007 addr0 / addr1  input  16  requester 0/1 EEPROM byte address; sampled at grant.
REQ-008 wdata0 / wdata1  input  8  requester 0/1 write data; sampled at grant.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse to requester 0/1.
REQ-010 err0 / err1  output  1  valid with ack; 1 = transaction timed out.
REQ-011 rdata  output  8  read data, or write read-back data; valid with ack0/ack1, held until next ack.
REQ-012 eep_enable  output  1  one-cycle command strobe to EEPROM byte port.
REQ-013 eep_wr  output  1  command type to EEPROM port: 1 = write, 0 = read.
REQ-014 eep_addr  output  16  command address; eep_wdata  output  8  command write data.
REQ-015 eep_valid  input  1  EEPROM port idle/result-ready; eep_rdata  input  8  EEPROM port result byte.

Function
REQ-016 States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP.
REQ-017 IDLE: when eep_valid=1 and any req, grant one requester, latch its we/addr/wdata into eep_wr/eep_addr/eep_wdata, go to ISSUE.
REQ-018 Arbitration round-robin: single requester wins; both requesting -> the one not granted last; last-granted pointer resets to 1 (requester 0 wins first tie).
REQ-019 ISSUE: eep_enable=1 for exactly one cycle, go to WAIT_BUSY; eep_enable=0 in every other state.
REQ-020 WAIT_BUSY: eep_valid=0 -> WAIT_DONE; ISSUE_CYC cycles without eep_valid falling -> timeout.
REQ-021 WAIT_DONE: eep_valid=1 -> capture eep_rdata into rdata, go to RESP; TIMEOUT_CYC cycles elapsed -> timeout.
REQ-022 Timeout: go to RESP with err=1; rdata unchanged.
REQ-023 RESP: pulse ack (and err) of granted requester for one cycle, update last-granted pointer, return to IDLE.
REQ-024 Latency from grant to ack: minimum 4 cycles plus EEPROM busy time; back-to-back grant no earlier than the cycle after RESP.
REQ-025 eep_wr/eep_addr/eep_wdata held stable from grant until return to IDLE.
REQ-026 Request deasserted after grant: transaction completes; ack still pulses.
REQ-027 Both requests rising in the same cycle with eep_valid=0: no grant until eep_valid=1.
REQ-028 Timeout counter single 32-bit, cleared on every state entry, saturates, never wraps.

Reset
REQ-029 On rst_n=0: state IDLE, eep_enable=0, eep_wr=0, eep_addr=0, eep_wdata=0, rdata=0, ack0/ack1=0, err0/err1=0, last-granted=1, counter=0.
REQ-030 Reset mid-transaction aborts it silently; no ack after reset release.

Configuration
REQ-031 Macro EEP_ARB_TIMEOUT_EN: defined -> timeouts per REQ-020..022 active.
REQ-032 Not defined -> WAIT_BUSY/WAIT_DONE wait indefinitely, err0/err1 tied 0, no counter logic.

Verification
REQ-033 Reset release, eep_valid=1, req0 read addr 0x0010, model returns 0x5A -> one eep_enable, eep_wr=0, eep_addr=0x0010, ack0 with rdata=0x5A, err0=0.
REQ-034 req0 and req1 asserted same cycle, three transactions each -> grants alternate 0,1,0,1,0,1.
REQ-035 req1 write addr 0x1234 data 0xC3, model echoes read-back 0xC3 -> eep_wr=1, eep_wdata=0xC3, ack1 with rdata=0xC3.
REQ-036 Macro defined, eep_valid never falls after enable -> ack0 with err0=1 exactly ISSUE_CYC cycles after WAIT_BUSY entry, rdata unchanged.
REQ-037 Macro defined, eep_valid stays 0 -> ack with err=1 after TIMEOUT_CYC (bench TIMEOUT_CYC=100).
REQ-038 rst_n pulsed low during WAIT_DONE -> all outputs at reset values, no ack afterwards, next req served normally.
